photon_maxi_deadlock_reporter: RTL

- Consumes per-instance block indications from the photon_maxi deadlock monitors.
- Declares a deadlock only when blocking persists for a configurable number of consecutive cycles.
- On a deadlock, latches a sticky flag and emits one timestamped report word on a valid/ready stream to the debug/status path.
- Re-arms once all block inputs clear.

---
 rtl/photon_maxi_deadlock_reporter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/photon_maxi_deadlock_reporter.sv
// photon_maxi_deadlock_reporter
// Watches the per-instance block levels from the photon_maxi deadlock
// monitors, declares a deadlock once blocking has persisted for THRESHOLD
// consecutive cycles, raises a sticky flag and emits one timestamped report
// word per blocking episode on a valid/ready stream.
module photon_maxi_deadlock_reporter #(
   parameter int NUM_MON   = 4,
   parameter int THRESHOLD = 1000,
   parameter int THRESH_W  = 16,
   parameter int TS_W      = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_MON-1:0] monitor_block,
   input  logic               clear,
   output logic               deadlock,
   output logic [63:0]        report_tdata,
   output logic               report_tvalid,
   input  logic               report_tready,
   output logic [1:0]         state_dbg
);

   if (NUM_MON < 1 || NUM_MON > 16) begin : g_bad_num_mon
      $error("NUM_MON must be in 1..16");
   end
   if (THRESHOLD < 1 || THRESHOLD >= 2**THRESH_W) begin : g_bad_threshold
      $error("THRESHOLD must be >= 1 and fit in THRESH_W bits");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WATCH  = 2'd1,
      REPORT = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t              state_q;
   logic [THRESH_W-1:0] cnt_q;
   logic [THRESH_W-1:0] cnt_d;
   logic [NUM_MON-1:0]  mask_q;
   logic [NUM_MON-1:0]  mask_d;
   logic [TS_W-1:0]     ts_q;
   logic [15:0]         seq_q;
   logic                deadlock_q;
   logic [63:0]         tdata_q;
   logic                tvalid_q;
   logic                any_block;
   logic                detect;

   // Episode bookkeeping: cnt and mask are zero whenever the FSM sits in
   // IDLE, so IDLE and WATCH share the same increment/accumulate path and a
   // THRESHOLD of 1 detects on the very first blocked sample.
   always_comb begin
      any_block = |monitor_block;
      cnt_d     = cnt_q + THRESH_W'(1);
      mask_d    = mask_q | monitor_block;
      detect    = any_block && (state_q == IDLE || state_q == WATCH) &&
                  (cnt_d == THRESH_W'(THRESHOLD));
   end

   // Detection FSM, timestamp, sticky flag and registered report stream.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mask_q     <= '0;
         ts_q       <= '0;
         seq_q      <= '0;
         deadlock_q <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);

         // Set beats clear when both land on the same edge.
         if (detect) begin
            deadlock_q <= 1'b1;
         end else if (clear) begin
            deadlock_q <= 1'b0;
         end

         case (state_q)
            IDLE, WATCH: begin
               if (!any_block) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  mask_q  <= '0;
               end else if (detect) begin
                  state_q  <= REPORT;
                  cnt_q    <= cnt_d;
                  mask_q   <= mask_d;
                  tdata_q  <= {seq_q, 16'(mask_d), 32'(ts_q)};
                  tvalid_q <= 1'b1;
               end else begin
                  state_q <= WATCH;
                  cnt_q   <= cnt_d;
                  mask_q  <= mask_d;
               end
            end
            // Block inputs are deliberately ignored until the sink takes the word.
            REPORT: begin
               if (report_tready) begin
                  tvalid_q <= 1'b0;
                  seq_q    <= seq_q + 16'd1;
                  state_q  <= HOLD;
               end
            end
            // Wait out the rest of this episode so it is reported only once.
            HOLD: begin
               if (!any_block) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  mask_q  <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign deadlock      = deadlock_q;
   assign report_tdata  = tdata_q;
   assign report_tvalid = tvalid_q;
   assign state_dbg     = state_q;

endmodule
